// File: rtl/timer_setter.sv
// Keypad entry, validation, parallel-load and 1 Hz tick generation for the M:SS down-counter chain.
// Optional macro TIMER_SETTER_QUICK30_EN: start on an empty entry loads 0:30.
module timer_setter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        zero_all,
  output logic [11:0] load_data,
  output logic        loadn,
  output logic        en,
  output logic        running,
  output logic        done,
  output logic        entry_err
);

  typedef enum logic [2:0] {S_ENTRY, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state, state_nx;
  logic [11:0]      digits, digits_nx;
  logic [CNT_W-1:0] presc, presc_nx;
  logic             err_nx, en_nx;

  assign load_data = digits;

  always_comb begin
    state_nx  = state;
    digits_nx = digits;
    presc_nx  = presc;
    err_nx    = entry_err;
    en_nx     = 1'b0;
    unique case (state)
      S_ENTRY: begin
        if (stop) begin
          digits_nx = '0;
          err_nx    = 1'b0;
        end else if (start) begin
          if (digits == '0) begin
`ifdef TIMER_SETTER_QUICK30_EN
            digits_nx = 12'h030;
            state_nx  = S_LOAD;
`endif
          end else if (digits[7:4] > 4'd5) begin
            err_nx = 1'b1;
          end else begin
            state_nx = S_LOAD;
          end
        end else if (key_valid) begin
          if (key_digit <= 4'd9) begin
            digits_nx = {digits[7:0], key_digit};
            err_nx    = 1'b0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        presc_nx = '0;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // zero_all wins so the tick that would land on 0:00 is suppressed
        if (zero_all) begin
          state_nx = S_DONE;
        end else if (stop) begin
          state_nx = S_PAUSE;
          err_nx   = 1'b0;
        end else begin
          en_nx    = (presc == PRESC_LAST);
          presc_nx = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_nx  = S_ENTRY;
          digits_nx = '0;
          err_nx    = 1'b0;
        end else if (start) begin
          state_nx = S_RUN;
        end
      end
      S_DONE: begin
        if (stop || start || key_valid) begin
          state_nx  = S_ENTRY;
          digits_nx = '0;
          if (stop) err_nx = 1'b0;
        end
      end
      default: state_nx = S_ENTRY;
    endcase
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_ENTRY;
      digits    <= '0;
      presc     <= '0;
      loadn     <= 1'b1;
      en        <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      state     <= state_nx;
      digits    <= digits_nx;
      presc     <= presc_nx;
      loadn     <= (state_nx != S_LOAD);
      en        <= en_nx;
      running   <= (state_nx == S_RUN);
      done      <= (state_nx == S_DONE);
      entry_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_timer_setter.sv
// Directed plus random bench for timer_setter against a behavioural cycle model.
module tb_timer_setter;
  localparam int TD = 4;
  localparam int M_ENTRY = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        clr, key_valid, start, stop, zero_all;
  logic [3:0]  key_digit;
  logic [11:0] load_data;
  logic        loadn, en, running, done, entry_err;

  timer_setter #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .zero_all(zero_all), .load_data(load_data),
    .loadn(loadn), .en(en), .running(running), .done(done), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: mode, three BCD digits (minutes, tens of s, ones of s), tick phase
  int mode = M_ENTRY;
  int d[3] = '{0, 0, 0};
  int phase = 0;
  bit m_err = 0, m_loadn = 1, m_en = 0;

  function automatic int m_data();
    return d[0] * 256 + d[1] * 16 + d[2];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_digits();
    d = '{0, 0, 0};
  endtask

  task automatic model_step();
    m_en = 0;
    if (clr) begin
      mode = M_ENTRY; clear_digits(); phase = 0; m_err = 0;
    end else begin
      case (mode)
        M_ENTRY:
          if (stop) begin clear_digits(); m_err = 0; end
          else if (start) begin
            if (m_data() == 0) begin
`ifdef TIMER_SETTER_QUICK30_EN
              d = '{0, 3, 0}; mode = M_LOAD;
`endif
            end else if (d[1] > 5) m_err = 1;
            else mode = M_LOAD;
          end else if (key_valid) begin
            if (int'(key_digit) < 10) begin
              d[0] = d[1]; d[1] = d[2]; d[2] = int'(key_digit); m_err = 0;
            end else m_err = 1;
          end
        M_LOAD: begin phase = 0; mode = M_RUN; end
        M_RUN:
          if (zero_all) mode = M_DONE;
          else if (stop) begin mode = M_PAUSE; m_err = 0; end
          else begin
            phase = (phase + 1) % TD;
            m_en = (phase == 0);
          end
        M_PAUSE:
          if (stop) begin mode = M_ENTRY; clear_digits(); m_err = 0; end
          else if (start) mode = M_RUN;
        M_DONE:
          if (stop || start || key_valid) begin
            mode = M_ENTRY; clear_digits();
            if (stop) m_err = 0;
          end
        default: mode = M_ENTRY;
      endcase
    end
    m_loadn = (mode != M_LOAD);
  endtask

  task automatic cyc(input bit c, input bit kv, input logic [3:0] kd,
                     input bit st, input bit sp, input bit za);
    clr = c; key_valid = kv; key_digit = kd; start = st; stop = sp; zero_all = za;
    @(posedge clk);
    model_step();
    #1;
    check("load_data", 32'(load_data), 32'(m_data()));
    check("loadn",     32'(loadn),     32'(m_loadn));
    check("en",        32'(en),        32'(m_en));
    check("running",   32'(running),   32'(mode == M_RUN));
    check("done",      32'(done),      32'(mode == M_DONE));
    check("entry_err", 32'(entry_err), 32'(m_err));
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] k);
    cyc(0, 1, k, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 4'h0, 0, 0, 0);
    check("reset_loadn", 32'(loadn), 32'd1);
    check("reset_data", 32'(load_data), 32'd0);

    // keys 1,3,0 then start; ticks every TD cycles
    key(4'd1); key(4'd3); key(4'd0);
    check("entry_130", 32'(load_data), 32'h130);
    cyc(0, 0, 4'h0, 1, 0, 0);
    check("load_strobe", 32'(loadn), 32'd0);
    idle();
    check("run_entry", 32'({running, loadn}), 32'b11);
    for (int i = 0; i < 12; i++) begin
      idle();
      check("tick_phase", 32'(en), 32'(i % TD == TD - 1));
    end

    // pause two cycles after a tick, then resume and cancel
    idle();
    cyc(0, 0, 4'h0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("pause_no_en", 32'({en, running}), 32'd0);
    end
    cyc(0, 0, 4'h0, 1, 0, 0);
    for (int i = 0; i < 6; i++) idle();
    cyc(0, 0, 4'h0, 0, 1, 0);
    cyc(0, 0, 4'h0, 0, 1, 0);
    check("cancel_data", 32'(load_data), 32'd0);

    // invalid time rejected, then fixed by another key
    key(4'd1); key(4'd7); key(4'd0);
    cyc(0, 0, 4'h0, 1, 0, 0);
    check("bad_time_err", 32'({entry_err, loadn}), 32'b11);
    key(4'd5);
    check("key_clears_err", 32'(entry_err), 32'd0);
    check("shift_705", 32'(load_data), 32'h705);

    // invalid key digit
    key(4'hB);
    check("bad_key_err", 32'(entry_err), 32'd1);
    check("bad_key_hold", 32'(load_data), 32'h705);
    cyc(0, 0, 4'h0, 0, 1, 0);
    check("stop_clear", 32'({entry_err, load_data}), 32'd0);

    // zero_all coincident with a due tick
    key(4'd0); key(4'd0); key(4'd1);
    cyc(0, 0, 4'h0, 1, 0, 0);
    idle();
    idle(); idle(); idle();
    cyc(0, 0, 4'h0, 0, 0, 1);
    check("zero_no_en", 32'({en, done}), 32'b01);
    key(4'd7);
    check("done_exit", 32'({done, load_data}), 32'd0);

    // reset in RUN together with start
    key(4'd2);
    cyc(0, 0, 4'h0, 1, 0, 0);
    idle(); idle();
    cyc(1, 0, 4'h0, 1, 0, 0);
    check("clr_mid_run", 32'({loadn, en, running, done, entry_err}), 32'b10000);
    cyc(0, 0, 4'h0, 1, 0, 0);
`ifdef TIMER_SETTER_QUICK30_EN
    check("quick30", 32'({loadn, load_data}), 32'h0030);
`else
    check("empty_start", 32'({loadn, load_data}), 32'h1000);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_setter.md
Name: timer_setter

Overview:
Front-end controller for the microwave timer digit chain. It takes keypad digits, shifts them into an M:SS entry register and validates them. It then drives the parallel-load strobe and data that the mod-6/mod-10 down-counter digits consume. While cooking it generates their 1 Hz count-enable pulse and watches for the chain reaching 0:00. It is the writer/driver side of the counters' load/enable interface.

Parameters:
TICK_DIV, 50000000, clk cycles per count-enable pulse (≥2)
CNT_W, 26, prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset, synchronous, active-high
key_valid  input  1  one-cycle strobe, key_digit valid
key_digit  input  4  keypad value
start  input  1  one-cycle start/resume request
stop  input  1  one-cycle pause/cancel request
zero_all  input  1  high when whole counter chain reads 0:00
load_data  output  12  {min_ones, sec_tens, sec_ones}, BCD, to counter data inputs
loadn  output  1  active-low parallel-load strobe to counters
en  output  1  one-cycle count-enable tick to counters
running  output  1  high in RUN
done  output  1  high in DONE
entry_err  output  1  invalid key or invalid time on start

Behaviour:
- Reset (clr=1 at edge, highest priority, any state): state=ENTRY, entry digits=0, prescaler=0, loadn=1, en=0, running=0, done=0, entry_err=0. All outputs registered.
- load_data always reflects the entry register.
- States: ENTRY, LOAD, RUN, PAUSE, DONE.
- Priority among same-cycle requests: stop > start > key_valid.
- ENTRY:
  - key_valid with key_digit ≤ 9: shift {min_ones,sec_tens,sec_ones} ← {sec_tens,sec_ones,key_digit}; entry_err←0.
  - key_valid with key_digit > 9: digits unchanged; entry_err←1, sticky until next valid key, stop, or clr.
  - stop: clear digits to 0, entry_err←0.
  - start with all digits 0: ignored (see optional feature).
  - start with sec_tens > 5: entry_err←1, stay in ENTRY.
  - Otherwise start → LOAD.
- LOAD: exactly one cycle. loadn=0 with load_data stable; prescaler←0; then → RUN. No requests are accepted during LOAD.
- RUN: running=1.
  - Prescaler counts 0..TICK_DIV-1 and wraps. en=1 in the cycle following prescaler==TICK_DIV-1, so the first en occurs TICK_DIV cycles after RUN entry; period is TICK_DIV.
  - zero_all=1 → DONE next cycle, with en forced 0 in that cycle.
  - stop → PAUSE, prescaler held.
  - key_valid and start are ignored.
- PAUSE: running=0, en=0.
  - start → RUN; prescaler resumes from the held value, so tick phase is preserved.
  - stop → ENTRY with digits cleared.
- DONE: done=1, en=0. Any of key_valid, start, or stop → ENTRY with digits cleared and done←0. The key itself is not entered.
- loadn and en are never asserted in the same cycle.

Optional Feature:
TIMER_SETTER_QUICK30_EN
- Defined: start in ENTRY with all digits 0 sets the entry register to 0:30 (0x030) and goes to LOAD, so load_data=0x030 during loadn.
- Not defined: that start is ignored and the block stays in ENTRY with no flag.

Test Plan:
1. TICK_DIV=4; keys 1,3,0 then start → load_data=0x130; loadn=0 for exactly one cycle on the edge after start. running=1 from the next cycle; en pulses at 4, 8, 12 cycles after RUN entry.
2. Keys 1,7,0 then start → entry_err=1, loadn stays 1, state ENTRY. Next key 5 → entry_err=0, load_data=0x705.
3. key_digit=0xB strobe → entry_err=1, load_data unchanged. stop → digits 0x000, entry_err=0.
4. RUN with TICK_DIV=4: stop 2 cycles after an en → no en during PAUSE; start → next en 2 cycles after resume. stop, stop → ENTRY, load_data=0x000.
5. zero_all=1 in RUN on the same cycle an en would fire → en stays 0, done=1 next cycle. key_valid → done=0, ENTRY, digits 0.
6. clr=1 mid-RUN and simultaneously with start → next edge: all outputs at reset values, state ENTRY. With TIMER_SETTER_QUICK30_EN, start on empty entry → loadn pulse with load_data=0x030.
